// File: rtl/cpu_pkg.sv
// cpu_pkg: state encodings, opcodes, ALU functions and widths for the control unit.
// Optional CPU_SINGLE_STEP_EN adds the WAIT state.
package cpu_pkg;
    localparam int DADDR_W = 8;
    localparam int RADDR_W = 4;
    localparam int OP_W    = 4;
    localparam int ALU_W   = 3;

    typedef enum logic [3:0] {
        S_INIT   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_NOOP   = 4'd3,
        S_LOAD_A = 4'd4,
        S_LOAD_B = 4'd5,
        S_STORE  = 4'd6,
        S_ADD    = 4'd7,
        S_SUB    = 4'd8,
        S_HALT   = 4'd9
`ifdef CPU_SINGLE_STEP_EN
        , S_WAIT = 4'd10
`endif
    } state_t;

    localparam logic [OP_W-1:0] OP_NOOP  = 4'd0;
    localparam logic [OP_W-1:0] OP_STORE = 4'd1;
    localparam logic [OP_W-1:0] OP_LOAD  = 4'd2;
    localparam logic [OP_W-1:0] OP_ADD   = 4'd3;
    localparam logic [OP_W-1:0] OP_SUB   = 4'd4;
    localparam logic [OP_W-1:0] OP_HALT  = 4'd5;

    localparam logic [ALU_W-1:0] ALU_PASS = 3'b000;
    localparam logic [ALU_W-1:0] ALU_ADD  = 3'b001;
    localparam logic [ALU_W-1:0] ALU_SUB  = 3'b010;
endpackage

// File: rtl/cpu_state_reg.sv
// cpu_state_reg: async-reset state register; with CPU_SINGLE_STEP_EN also the previous-Step flop.
module cpu_state_reg
    import cpu_pkg::*;
(
    input  logic   clk_i,
    input  logic   rst_ni,
`ifdef CPU_SINGLE_STEP_EN
    input  logic   step_i,
    output logic   step_q_o,
`endif
    input  state_t state_d_i,
    output state_t state_q_o
);
    state_t state_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= S_INIT;
        else         state_q <= state_d_i;
    end

    assign state_q_o = state_q;

`ifdef CPU_SINGLE_STEP_EN
    logic step_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) step_q <= 1'b0;
        else         step_q <= step_i;
    end

    assign step_q_o = step_q;
`endif
endmodule

// File: rtl/cpu_control_unit.sv
// cpu_control_unit: Moore FSM sequencing fetch/decode/execute for the 16-bit datapath.
// Optional CPU_SINGLE_STEP_EN gates each FETCH behind a rising edge of Step.
module cpu_control_unit
    import cpu_pkg::*;
(
    input  logic               Clk,
    input  logic               ResetN,
`ifdef CPU_SINGLE_STEP_EN
    input  logic               Step,
`endif
    input  logic [15:0]        IR,
    output logic               PC_clr,
    output logic               PC_up,
    output logic               IR_ld,
    output logic [DADDR_W-1:0] D_addr,
    output logic               D_wr,
    output logic               RF_s,
    output logic [RADDR_W-1:0] RF_W_addr,
    output logic               RF_W_en,
    output logic [RADDR_W-1:0] RF_Ra_addr,
    output logic [RADDR_W-1:0] RF_Rb_addr,
    output logic [ALU_W-1:0]   Alu_s0,
    output logic [3:0]         State,
    output logic               Halted
);
    state_t          state_q, state_d, go_s;
    logic [OP_W-1:0] op;
    logic            ld, st, ar;

    assign op = IR[15:12];

`ifdef CPU_SINGLE_STEP_EN
    logic step_q;
    assign go_s = S_WAIT;
`else
    assign go_s = S_FETCH;
`endif

    cpu_state_reg u_state_reg (
        .clk_i     (Clk),
        .rst_ni    (ResetN),
`ifdef CPU_SINGLE_STEP_EN
        .step_i    (Step),
        .step_q_o  (step_q),
`endif
        .state_d_i (state_d),
        .state_q_o (state_q)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_INIT, S_NOOP, S_LOAD_B, S_STORE, S_ADD, S_SUB: state_d = go_s;
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: state_d = op == OP_NOOP  ? S_NOOP   :
                                op == OP_STORE ? S_STORE  :
                                op == OP_LOAD  ? S_LOAD_A :
                                op == OP_ADD   ? S_ADD    :
                                op == OP_SUB   ? S_SUB    :
                                op == OP_HALT  ? S_HALT   : S_NOOP;
            S_LOAD_A: state_d = S_LOAD_B;
            S_HALT:   state_d = S_HALT;
`ifdef CPU_SINGLE_STEP_EN
            S_WAIT:   state_d = (Step && !step_q) ? S_FETCH : S_WAIT;
`endif
            default:  state_d = S_INIT;
        endcase
    end

    assign ld = state_q == S_LOAD_A || state_q == S_LOAD_B;
    assign st = state_q == S_STORE;
    assign ar = state_q == S_ADD || state_q == S_SUB;

    // INIT is also the reset state, so the PC clear is held off until ResetN releases
    assign PC_clr     = ResetN && state_q == S_INIT;
    assign PC_up      = state_q == S_FETCH;
    assign IR_ld      = state_q == S_FETCH;
    assign D_addr     = (ld || st) ? IR[4 +: DADDR_W] : '0;
    assign D_wr       = st;
    assign RF_s       = ld;
    assign RF_W_en    = state_q == S_LOAD_B || ar;
    assign RF_W_addr  = RF_W_en ? IR[3:0] : '0;
    assign RF_Ra_addr = st ? IR[3:0] : ar ? IR[11:8] : '0;
    assign RF_Rb_addr = ar ? IR[7:4] : '0;
    assign Alu_s0     = state_q == S_ADD ? ALU_ADD : state_q == S_SUB ? ALU_SUB : ALU_PASS;
    assign State      = state_q;
    assign Halted     = state_q == S_HALT;
endmodule

// File: tb/tb_cpu_control_unit.sv
// tb_cpu_control_unit: randomized instruction stream checked against a per-instruction state/output model.
module tb_cpu_control_unit;
    logic        Clk = 1'b0;
    logic        ResetN = 1'b1;
    logic        Step = 1'b0;
    logic [15:0] IR = 16'h0;
    logic        PC_clr, PC_up, IR_ld, D_wr, RF_s, RF_W_en, Halted;
    logic [7:0]  D_addr;
    logic [3:0]  RF_W_addr, RF_Ra_addr, RF_Rb_addr, State;
    logic [2:0]  Alu_s0;
    int          checks = 0;
    int          failures = 0;

    wire [33:0] obs = {State, PC_clr, PC_up, IR_ld, D_addr, D_wr, RF_s, RF_W_addr, RF_W_en,
                       RF_Ra_addr, RF_Rb_addr, Alu_s0, Halted};

    cpu_control_unit dut (
        .Clk(Clk), .ResetN(ResetN),
`ifdef CPU_SINGLE_STEP_EN
        .Step(Step),
`endif
        .IR(IR), .PC_clr(PC_clr), .PC_up(PC_up), .IR_ld(IR_ld), .D_addr(D_addr), .D_wr(D_wr),
        .RF_s(RF_s), .RF_W_addr(RF_W_addr), .RF_W_en(RF_W_en), .RF_Ra_addr(RF_Ra_addr),
        .RF_Rb_addr(RF_Rb_addr), .Alu_s0(Alu_s0), .State(State), .Halted(Halted)
    );

    always #5 Clk = ~Clk;

    // expected output table for a given state and instruction word
    function automatic logic [33:0] expo(input int es, input logic [15:0] ir);
        logic ld, st, ar, we;
        ld = es == 4 || es == 5;
        st = es == 6;
        ar = es == 7 || es == 8;
        we = es == 5 || ar;
        return {4'(es), es == 0, es == 1, es == 1, (ld || st) ? ir[11:4] : 8'h00, st, ld,
                we ? ir[3:0] : 4'h0, we, st ? ir[3:0] : ar ? ir[11:8] : 4'h0,
                ar ? ir[7:4] : 4'h0, es == 7 ? 3'b001 : es == 8 ? 3'b010 : 3'b000, es == 9};
    endfunction

    task automatic tick(input logic [15:0] v);
        @(posedge Clk);
        #1 IR = v;
        #1;
    endtask

    task automatic go_fetch(input string nm);
`ifdef CPU_SINGLE_STEP_EN
        for (int k = 0; k < 3; k++) begin
            if (k == 2) Step = 1'b0;
            tick(16'($urandom));
            checks++;
            if (obs !== expo(10, IR)) begin
                failures++;
                $display("FAIL %s wait%0d obs=%h exp=%h", nm, k, obs, expo(10, IR));
            end
        end
        Step = 1'b1;
`endif
        tick(16'($urandom));
        checks++;
        if (obs !== expo(1, IR)) begin
            failures++;
            $display("FAIL %s fetch obs=%h exp=%h", nm, obs, expo(1, IR));
        end
    endtask

    task automatic run_instr(input logic [15:0] ir, input string nm);
        int q[$];
        int op = int'(ir[15:12]);
        q.push_back(2);
        case (op)
            1: q.push_back(6);
            2: begin q.push_back(4); q.push_back(5); end
            3: q.push_back(7);
            4: q.push_back(8);
            5: repeat (21) q.push_back(9);
            default: q.push_back(3);
        endcase
        foreach (q[i]) begin
            tick(ir);
            checks++;
            if (obs !== expo(q[i], ir)) begin
                failures++;
                $display("FAIL %s cyc%0d ir=%h obs=%h exp=%h", nm, i, ir, obs, expo(q[i], ir));
            end
            checks++;
            if ((RF_W_en && D_wr) || (PC_up && State != 4'd1)) begin
                failures++;
                $display("FAIL %s invariant we=%b wr=%b up=%b st=%0d required=exclusive", nm, RF_W_en, D_wr, PC_up, State);
            end
        end
        if (op != 5) go_fetch(nm);
    endtask

    task automatic test_reset();
        #1 ResetN = 1'b0;
        #1;
        checks++;
        if (obs !== 34'h0) begin
            failures++;
            $display("FAIL reset_hold obs=%h exp=%h", obs, 34'h0);
        end
        repeat (3) @(posedge Clk);
        #1 ResetN = 1'b1;
        #1;
        checks++;
        if (obs !== expo(0, IR)) begin
            failures++;
            $display("FAIL reset_init obs=%h exp=%h", obs, expo(0, IR));
        end
        go_fetch("boot");
    endtask

    task automatic test_directed();
        run_instr(16'h21B3, "load");
        run_instr(16'h3125, "add");
        run_instr(16'h4125, "sub");
        run_instr(16'h1404, "store");
        run_instr(16'hF000, "undef");
        run_instr(16'h0ABC, "noop");
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            logic [15:0] ir = 16'($urandom);
            if (ir[15:12] == 4'd5) ir[15:12] = 4'($urandom_range(0, 4));
            run_instr(ir, "rand");
        end
    endtask

    task automatic test_mid_reset();
        int seq[3] = '{2, 4, 5};
        foreach (seq[i]) begin
            tick(16'h21B3);
            checks++;
            if (obs !== expo(seq[i], IR)) begin
                failures++;
                $display("FAIL midrst_pre%0d obs=%h exp=%h", i, obs, expo(seq[i], IR));
            end
        end
        #2 ResetN = 1'b0;
        #1;
        checks++;
        if (RF_W_en !== 1'b0 || State !== 4'd0 || obs !== 34'h0) begin
            failures++;
            $display("FAIL midrst_async we=%b state=%0d obs=%h exp=%h", RF_W_en, State, obs, 34'h0);
        end
        @(posedge Clk);
        #1 ResetN = 1'b1;
        #1;
        checks++;
        if (obs !== expo(0, IR)) begin
            failures++;
            $display("FAIL midrst_init obs=%h exp=%h", obs, expo(0, IR));
        end
        go_fetch("midrst");
    endtask

    task automatic test_halt();
        run_instr(16'h5000, "halt");
        #2 ResetN = 1'b0;
        #1;
        checks++;
        if (obs !== 34'h0) begin
            failures++;
            $display("FAIL halt_reset obs=%h exp=%h", obs, 34'h0);
        end
        @(posedge Clk);
        #1 ResetN = 1'b1;
        #1;
        checks++;
        if (obs !== expo(0, IR)) begin
            failures++;
            $display("FAIL halt_init obs=%h exp=%h", obs, expo(0, IR));
        end
        go_fetch("after_halt");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_mid_reset();
        run_instr(16'h3ABC, "post_reset_add");
        test_halt();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
